// File: rtl/alu_op_sequencer.sv
// Command sequencer for the 8-bit ALU/operand-mux datapath: owns the A, B and
// accumulator operand registers and returns each EXEC result over a valid/ready port.
module alu_op_sequencer #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16,
  parameter int ACC_WB    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [1:0]           cmd_func,
  input  logic                 cmd_sel,
  input  logic [WIDTH-1:0]     cmd_data,
  output logic [WIDTH-1:0]     dp_inbus,
  output logic [WIDTH-1:0]     dp_aside,
  output logic [WIDTH-1:0]     dp_bside,
  output logic                 dp_sel,
  output logic [1:0]           dp_func,
  input  logic [WIDTH-1:0]     dp_outbus,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_data,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Operand slots are indexed by their LOAD opcode, so cmd_op selects the slot directly.
  localparam int N_OPND  = 3;
  localparam int IDX_A   = 0;
  localparam int IDX_B   = 1;
  localparam int IDX_ACC = 2;
  localparam logic [1:0] OP_EXEC = 2'b11;

  state_t               state_reg, state_next;
  logic                 sel_reg, sel_next;
  logic [1:0]           func_reg, func_next;
  logic                 res_valid_reg, res_valid_next;
  logic [WIDTH-1:0]     res_data_reg, res_data_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;

  logic                 cmd_accept;
  logic                 capture_en;
  logic [N_OPND-1:0][WIDTH-1:0] opnd_q;

  assign cmd_accept = cmd_valid && (state_reg == ST_IDLE);
  assign capture_en = (state_reg == ST_EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      sel_reg       <= 1'b0;
      func_reg      <= 2'b00;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      func_reg      <= func_next;
      res_valid_reg <= res_valid_next;
      res_data_reg  <= res_data_next;
      cnt_reg       <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    func_next      = func_reg;
    res_valid_next = res_valid_reg;
    res_data_next  = res_data_reg;
    cnt_next       = cnt_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (cmd_accept && (cmd_op == OP_EXEC)) begin
          func_next  = cmd_func;
          sel_next   = cmd_sel;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Datapath inputs were registered last edge, so dp_outbus has settled by now.
        res_data_next  = dp_outbus;
        res_valid_next = 1'b1;
        state_next     = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) begin
          res_valid_next = 1'b0;
          cnt_next       = cnt_reg + CNT_WIDTH'(1);
          state_next     = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < N_OPND; gi++) begin : g_opnd
      localparam bit WB_EN = (gi == IDX_ACC) && (ACC_WB != 0);
      logic [WIDTH-1:0] q_reg, q_next;
      logic             load_en;

      assign load_en = cmd_accept && (cmd_op == 2'(gi));

      // Loads happen only in IDLE and write-back only in EXEC, so they never collide.
      always_comb begin
        q_next = q_reg;
        if (load_en) begin
          q_next = cmd_data;
        end else if (WB_EN && capture_en) begin
          q_next = dp_outbus;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else begin
          q_reg <= q_next;
        end
      end

      assign opnd_q[gi] = q_reg;
    end
  endgenerate

  assign cmd_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign dp_aside  = opnd_q[IDX_A];
  assign dp_bside  = opnd_q[IDX_B];
  assign dp_inbus  = opnd_q[IDX_ACC];
  assign dp_sel    = sel_reg;
  assign dp_func   = func_reg;
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign op_count  = cnt_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (ACC_WB=1/CNT_WIDTH=16 and ACC_WB=0/CNT_WIDTH=4)
// share directed stimulus and are checked every cycle against a transaction-level model.
module tb_alu_op_sequencer;

  localparam logic [1:0] LOADA = 2'b00, LOADB = 2'b01, LOADACC = 2'b10, EXEC = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [1:0] cmd_func = 2'b00;
  logic       cmd_sel = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       res_ready = 1'b0;

  logic        cmd_ready_o [2];
  logic        busy_o      [2];
  logic        res_valid_o [2];
  logic        sel_o       [2];
  logic [1:0]  func_o      [2];
  logic [7:0]  inbus_o     [2];
  logic [7:0]  aside_o     [2];
  logic [7:0]  bside_o     [2];
  logic [7:0]  res_data_o  [2];
  logic [7:0]  outbus      [2];
  logic [15:0] cnt_o       [2];
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [7:0] x, input logic [7:0] y, input logic [1:0] f);
    case (f)
      2'b00:   return x + y;
      2'b01:   return x - y;
      2'b10:   return x & y;
      default: return x | y;
    endcase
  endfunction

  assign outbus[0] = alu(inbus_o[0], sel_o[0] ? aside_o[0] : bside_o[0], func_o[0]);
  assign outbus[1] = alu(inbus_o[1], sel_o[1] ? aside_o[1] : bside_o[1], func_o[1]);
  assign cnt_o[0]  = cnt0;
  assign cnt_o[1]  = {12'h000, cnt1};

  alu_op_sequencer #(.WIDTH(8), .CNT_WIDTH(16), .ACC_WB(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_o[0]),
    .cmd_op(cmd_op), .cmd_func(cmd_func), .cmd_sel(cmd_sel), .cmd_data(cmd_data),
    .dp_inbus(inbus_o[0]), .dp_aside(aside_o[0]), .dp_bside(bside_o[0]),
    .dp_sel(sel_o[0]), .dp_func(func_o[0]), .dp_outbus(outbus[0]),
    .res_valid(res_valid_o[0]), .res_ready(res_ready), .res_data(res_data_o[0]),
    .busy(busy_o[0]), .op_count(cnt0)
  );

  alu_op_sequencer #(.WIDTH(8), .CNT_WIDTH(4), .ACC_WB(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_o[1]),
    .cmd_op(cmd_op), .cmd_func(cmd_func), .cmd_sel(cmd_sel), .cmd_data(cmd_data),
    .dp_inbus(inbus_o[1]), .dp_aside(aside_o[1]), .dp_bside(bside_o[1]),
    .dp_sel(sel_o[1]), .dp_func(func_o[1]), .dp_outbus(outbus[1]),
    .res_valid(res_valid_o[1]), .res_ready(res_ready), .res_data(res_data_o[1]),
    .busy(busy_o[1]), .op_count(cnt1)
  );

  // Model: an operation is either absent, computing (the one settle cycle) or awaiting pickup.
  int         m_wb  [2] = '{1, 0};
  int         m_mod [2] = '{65536, 16};
  bit         m_busy [2];
  bit         m_calc [2];
  bit         m_valid[2];
  bit         m_sel  [2];
  logic [1:0] m_func [2];
  logic [7:0] m_a [2], m_b [2], m_acc [2], m_res [2];
  int         m_cnt [2];

  always @(posedge clk or negedge rst_n) begin
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        m_busy[m] = 0; m_calc[m] = 0; m_valid[m] = 0; m_sel[m] = 0; m_func[m] = 0;
        m_a[m] = 0; m_b[m] = 0; m_acc[m] = 0; m_res[m] = 0; m_cnt[m] = 0;
      end else if (!m_busy[m]) begin
        if (cmd_valid) begin
          if (cmd_op == LOADA) m_a[m] = cmd_data;
          else if (cmd_op == LOADB) m_b[m] = cmd_data;
          else if (cmd_op == LOADACC) m_acc[m] = cmd_data;
          else begin
            m_func[m] = cmd_func; m_sel[m] = cmd_sel; m_busy[m] = 1; m_calc[m] = 1;
          end
        end
      end else if (m_calc[m]) begin
        m_res[m] = alu(m_acc[m], m_sel[m] ? m_a[m] : m_b[m], m_func[m]);
        if (m_wb[m] != 0) m_acc[m] = m_res[m];
        m_valid[m] = 1; m_calc[m] = 0;
      end else if (m_valid[m] && res_ready) begin
        m_valid[m] = 0; m_busy[m] = 0; m_cnt[m] = (m_cnt[m] + 1) % m_mod[m];
      end
    end
  end

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, m, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      for (int m = 0; m < 2; m++) begin
        chk("cmd_ready", m, cmd_ready_o[m], !m_busy[m]);
        chk("busy",      m, busy_o[m],      m_busy[m]);
        chk("res_valid", m, res_valid_o[m], m_valid[m]);
        chk("res_data",  m, res_data_o[m],  m_res[m]);
        chk("dp_aside",  m, aside_o[m],     m_a[m]);
        chk("dp_bside",  m, bside_o[m],     m_b[m]);
        chk("dp_inbus",  m, inbus_o[m],     m_acc[m]);
        chk("dp_sel",    m, sel_o[m],       m_sel[m]);
        chk("dp_func",   m, func_o[m],      m_func[m]);
        chk("op_count",  m, cnt_o[m],       m_cnt[m]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] f, input logic s, input logic [7:0] d);
    int w = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_func = f; cmd_sel = s; cmd_data = d;
    while (!cmd_ready_o[0] && w < 50) begin
      tick();
      w++;
    end
    chk("send_timeout", 0, w < 50, 1);
    tick();
    $display("cmd op=%0d func=%0d sel=%0d data=%02h accepted @%0t", op, f, s, d, $time);
    cmd_valid = 1'b0; cmd_op = 'x; cmd_func = 'x; cmd_sel = 'x; cmd_data = 'x;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then abort an EXEC with reset.
    repeat (3) @(posedge clk);
    #2;
    checking = 1'b1;
    chk("rst_res_valid", 0, res_valid_o[0], 0);
    chk("rst_op_count", 1, cnt_o[1], 0);
    rst_n = 1'b1;
    chk("rst_rel_ready", 0, cmd_ready_o[0], 1);
    send(LOADA, 2'b00, 1'b0, 8'h77);
    send(EXEC, 2'b10, 1'b1, 8'h00);
    chk("pre_abort_busy", 0, busy_o[0], 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 0, busy_o[0], 0);
    chk("abort_aside", 0, aside_o[0], 8'h00);
    chk("abort_func", 0, func_o[0], 2'b00);
    chk("abort_sel", 0, sel_o[0], 0);
    chk("abort_res_valid", 0, res_valid_o[0], 0);
    tick();
    rst_n = 1'b1;
    chk("abort_rel_ready", 0, cmd_ready_o[0], 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_result", 0, res_valid_o[0], 0);
    end

    // Back-to-back loads.
    send(LOADA, 2'b00, 1'b0, 8'h12);
    chk("b2b_ready1", 0, cmd_ready_o[0], 1);
    send(LOADB, 2'b00, 1'b0, 8'h34);
    chk("b2b_ready2", 0, cmd_ready_o[0], 1);
    send(LOADACC, 2'b00, 1'b0, 8'h01);
    chk("b2b_ready3", 0, cmd_ready_o[0], 1);
    chk("load_aside", 0, aside_o[0], 8'h12);
    chk("load_bside", 0, bside_o[0], 8'h34);
    chk("load_inbus", 0, inbus_o[0], 8'h01);

    // EXEC add with A side, consumer ready.
    res_ready = 1'b1;
    send(EXEC, 2'b00, 1'b1, 8'h00);
    chk("add_busy", 0, busy_o[0], 1);
    chk("add_early_valid", 0, res_valid_o[0], 0);
    tick();
    chk("add_valid", 0, res_valid_o[0], 1);
    chk("add_data", 0, res_data_o[0], 8'h13);
    chk("add_acc_wb", 0, inbus_o[0], 8'h13);
    chk("add_acc_nowb", 1, inbus_o[1], 8'h01);
    tick();
    chk("add_idle", 0, cmd_ready_o[0], 1);
    chk("add_count", 0, cnt_o[0], 1);
    $display("exec add result=%02h count=%0d @%0t", res_data_o[0], cnt_o[0], $time);
    res_ready = 1'b0;

    // EXEC sub with B side under backpressure, LOADA held meanwhile.
    send(EXEC, 2'b01, 1'b0, 8'h00);
    cmd_valid = 1'b1; cmd_op = LOADA; cmd_data = 8'h55; cmd_func = 2'b00; cmd_sel = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 0, res_valid_o[0], 1);
      chk("stall_data", 0, res_data_o[0], 8'hDF);
      chk("stall_data", 1, res_data_o[1], 8'hCD);
      chk("stall_ready", 0, cmd_ready_o[0], 0);
      chk("stall_aside", 0, aside_o[0], 8'h12);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("stall_release", 0, cmd_ready_o[0], 1);
    chk("stall_aside_hold", 0, aside_o[0], 8'h12);
    chk("stall_count", 0, cnt_o[0], 2);
    tick();
    cmd_valid = 1'b0;
    chk("held_loada", 0, aside_o[0], 8'h55);
    $display("exec sub result=%02h/%02h, held LOADA landed @%0t", m_res[0], m_res[1], $time);

    // Chained add wraps to zero; only the write-back build updates the accumulator.
    send(LOADACC, 2'b00, 1'b0, 8'hFF);
    send(LOADB, 2'b00, 1'b0, 8'h01);
    res_ready = 1'b1;
    send(EXEC, 2'b00, 1'b0, 8'h00);
    tick();
    chk("wrap_data", 0, res_data_o[0], 8'h00);
    chk("wrap_data", 1, res_data_o[1], 8'h00);
    chk("wrap_acc_wb", 0, inbus_o[0], 8'h00);
    chk("wrap_acc_nowb", 1, inbus_o[1], 8'hFF);
    tick();
    chk("wrap_count", 0, cnt_o[0], 3);
    $display("exec wrap result=%02h inbus=%02h/%02h @%0t", res_data_o[0], inbus_o[0], inbus_o[1], $time);

    // EXEC presented across reset release, then 16 completions wrap the 4-bit counter.
    rst_n = 1'b0;
    tick();
    cmd_valid = 1'b1; cmd_op = EXEC; cmd_func = 2'b11; cmd_sel = 1'b1; cmd_data = 8'h00;
    rst_n = 1'b1;
    tick();
    chk("rel_exec_accepted", 0, busy_o[0], 1);
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("rel_exec_count", 0, cnt_o[0], 1);
    for (int k = 1; k < 16; k++) begin
      send(EXEC, 2'b11, 1'b1, 8'h00);
      tick();
      tick();
      if (k == 14) chk("cnt_15", 1, cnt_o[1], 15);
    end
    chk("cnt_wrap", 1, cnt_o[1], 0);
    chk("cnt_16", 0, cnt_o[0], 16);
    $display("16 execs done count=%0d/%0d @%0t", cnt_o[0], cnt_o[1], $time);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
